// File: rtl/fft_pkg_5.sv
// Shared definitions for the 8-point FFT front end.
//   DATA_W          : sample width, equal to the FFT input width
//   FFT_N           : FFT size / window length
//   FFT_LAT_DEFAULT : register stages inside the FFT pipeline
//   sample_t        : one audio sample (unsigned ADC code)
package fft_pkg_5;
   localparam int DATA_W          = 12;
   localparam int FFT_N           = 8;
   localparam int FFT_LAT_DEFAULT = 3;

   typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/fft_frame_buffer_5_valid_delay_line.sv
// valid_delay_line: delays a 1-bit strobe by DEPTH clock cycles.
// Each input pulse travels on its own, so back-to-back pulses stay
// separate. A synchronous reset flushes every pulse in flight.
//   clk  : clock
//   rst  : synchronous active-high reset
//   din  : strobe in
//   dout : strobe out, DEPTH cycles later
module valid_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fft_frame_buffer_5.sv
// fft_frame_buffer_5: builds sliding windows of N samples from a serial
// sample stream and presents each one to the FFT as stable parallel inputs.
// A new window is emitted every HOP accepted samples, after an initial fill
// of N samples.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop the partial window and restart the fill
//   s_valid/s_ready : sample handshake; a sample is taken on a clock edge
//                     where both are high. s_ready only drops during reset.
//   s_data          : sample value
//   x_0 .. x_7      : held window, x_0 oldest, x_7 newest
//   frame_valid     : one-cycle pulse, a new window is on x_*
//   fft_out_valid   : frame_valid delayed by FFT_LAT cycles
//   frame_cnt       : emitted frames, modulo 256
module fft_frame_buffer_5 #(
   parameter int DATA_W  = fft_pkg_5::DATA_W,
   parameter int N       = fft_pkg_5::FFT_N,
   parameter int HOP     = 8,
   parameter int FFT_LAT = fft_pkg_5::FFT_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic [DATA_W-1:0] x_0,
   output logic [DATA_W-1:0] x_1,
   output logic [DATA_W-1:0] x_2,
   output logic [DATA_W-1:0] x_3,
   output logic [DATA_W-1:0] x_4,
   output logic [DATA_W-1:0] x_5,
   output logic [DATA_W-1:0] x_6,
   output logic [DATA_W-1:0] x_7,
   output logic              frame_valid,
   output logic              fft_out_valid,
   output logic [7:0]        frame_cnt
);
   import fft_pkg_5::*;

   localparam int CNT_W = $clog2(N + 1);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [CNT_W-1:0]  fill_cnt;
   logic [CNT_W-1:0]  hop_cnt;
   logic [DATA_W-1:0] win      [N];
   logic [DATA_W-1:0] next_win [N];
   logic [DATA_W-1:0] x_hold   [N];
   logic              accept;
   logic              emit;

   // Flush takes priority: a sample offered in the flush cycle is dropped.
   assign accept = s_valid && s_ready && !flush;

   // Window as it will look after this edge's accept; x_* are loaded from
   // this so the emitted frame includes the completing sample.
   always_comb begin
      for (int i = 0; i < N - 1; i++) begin
         next_win[i] = win[i+1];
      end
      next_win[N-1] = s_data;
   end

   always_comb begin
      emit = 1'b0;
      if (accept) begin
         if (state == ST_FILL) emit = (fill_cnt == CNT_W'(N - 1));
         else                  emit = (hop_cnt  == CNT_W'(HOP - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_FILL;
         fill_cnt    <= '0;
         hop_cnt     <= '0;
         s_ready     <= 1'b0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         for (int i = 0; i < N; i++) begin
            win[i]    <= '0;
            x_hold[i] <= '0;
         end
      end else begin
         s_ready     <= 1'b1;
         frame_valid <= emit;

         if (flush) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            hop_cnt  <= '0;
         end else if (accept) begin
            win <= next_win;
            if (state == ST_FILL) begin
               if (fill_cnt == CNT_W'(N - 1)) begin
                  fill_cnt <= CNT_W'(N);
                  hop_cnt  <= '0;
                  state    <= ST_RUN;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end else begin
               if (hop_cnt == CNT_W'(HOP - 1)) hop_cnt <= '0;
               else                            hop_cnt <= hop_cnt + 1'b1;
            end
         end

         // Hold register only changes at emission, so the FFT sees a
         // stable window while its pipeline runs.
         if (emit) begin
            x_hold    <= next_win;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Flush does not touch this pipe: frames already emitted still signal.
   valid_delay_line #(
      .DEPTH (FFT_LAT)
   ) u_lat (
      .clk  (clk),
      .rst  (rst),
      .din  (frame_valid),
      .dout (fft_out_valid)
   );

   assign x_0 = x_hold[0];
   assign x_1 = x_hold[1];
   assign x_2 = x_hold[2];
   assign x_3 = x_hold[3];
   assign x_4 = x_hold[4];
   assign x_5 = x_hold[5];
   assign x_6 = x_hold[6];
   assign x_7 = x_hold[7];
endmodule

// File: tb/tb_fft_frame_buffer_5.sv
// Bench for fft_frame_buffer_5. Three instances (HOP = 8, 4, 1) share the
// same stimulus; sel picks the instance whose outputs are compared.
module tb_fft_frame_buffer_5;
   localparam int W   = 12;
   localparam int N   = 8;
   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         s_valid = 1'b0;
   logic [W-1:0] s_data = '0;

   logic         rdy  [3];
   logic         fv   [3];
   logic         fov  [3];
   logic [7:0]   fcnt [3];
   logic [W-1:0] xo   [3][N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fft_frame_buffer_5 #(
         .HOP ((g == 0) ? 8 : ((g == 1) ? 4 : 1))
      ) dut (
         .clk           (clk),
         .rst           (rst),
         .flush         (flush),
         .s_valid       (s_valid),
         .s_data        (s_data),
         .s_ready       (rdy[g]),
         .x_0           (xo[g][0]),
         .x_1           (xo[g][1]),
         .x_2           (xo[g][2]),
         .x_3           (xo[g][3]),
         .x_4           (xo[g][4]),
         .x_5           (xo[g][5]),
         .x_6           (xo[g][6]),
         .x_7           (xo[g][7]),
         .frame_valid   (fv[g]),
         .fft_out_valid (fov[g]),
         .frame_cnt     (fcnt[g])
      );
   end

   // ---------------- bench state ----------------
   int checks = 0;
   int failures = 0;
   int sel = 0;
   int hop = 8;
   bit mon_on = 1'b0;
   int frames_seen = 0;
   int fov_seen = 0;

   logic [N*W-1:0] exp_q[$];
   logic [N*W-1:0] x_exp = '0;
   logic [W-1:0]   hist[$];
   int             mcnt = 0;
   bit             mrun = 1'b0;
   bit             emit_exp = 1'b0;

   // Expected strobes derived from the emissions the driver predicted.
   logic           fv_exp = 1'b0;
   logic [LAT-1:0] lat_exp = '0;
   logic [7:0]     fc_exp = '0;
   logic           rdy_exp = 1'b0;

   function automatic logic [N*W-1:0] pack_hist();
      logic [N*W-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) p[i*W +: W] = hist[i];
      return p;
   endfunction

   function automatic logic [N*W-1:0] win_of(input int s);
      logic [N*W-1:0] p;
      for (int i = 0; i < N; i++) p[i*W +: W] = xo[s][i];
      return p;
   endfunction

   always @(posedge clk) begin
      rdy_exp <= !rst;
      if (rst) begin
         fv_exp  <= 1'b0;
         lat_exp <= '0;
         fc_exp  <= '0;
      end else begin
         fv_exp  <= emit_exp;
         lat_exp <= {lat_exp[LAT-2:0], fv_exp};
         if (emit_exp) fc_exp <= fc_exp + 8'd1;
      end
   end

   // Monitor / scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (fv[sel] !== fv_exp) begin
            failures++;
            $display("FAIL frame_valid t=%0t got=%b exp=%b", $time, fv[sel], fv_exp);
         end
         checks++;
         if (fov[sel] !== lat_exp[LAT-1]) begin
            failures++;
            $display("FAIL fft_out_valid t=%0t got=%b exp=%b", $time, fov[sel], lat_exp[LAT-1]);
         end
         checks++;
         if (fcnt[sel] !== fc_exp) begin
            failures++;
            $display("FAIL frame_cnt t=%0t got=%0d exp=%0d", $time, fcnt[sel], fc_exp);
         end
         checks++;
         if (rdy[sel] !== rdy_exp) begin
            failures++;
            $display("FAIL s_ready t=%0t got=%b exp=%b", $time, rdy[sel], rdy_exp);
         end
         if (fov[sel] === 1'b1) fov_seen++;
         if (fv[sel] === 1'b1) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL window_unexpected t=%0t got=%h exp=none", $time, win_of(sel));
            end else begin
               x_exp = exp_q.pop_front();
            end
         end
         // Outside emissions this also proves x_* hold still.
         checks++;
         if (win_of(sel) !== x_exp) begin
            failures++;
            $display("FAIL window t=%0t got=%h exp=%h", $time, win_of(sel), x_exp);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input logic [W-1:0] d, input bit f);
      s_valid  = v;
      s_data   = d;
      flush    = f;
      emit_exp = 1'b0;
      if (!rst) begin
         if (f) begin
            mcnt = 0;
            mrun = 1'b0;
            hist.delete();
         end else if (v) begin
            hist.push_back(d);
            if (hist.size() > N) void'(hist.pop_front());
            mcnt++;
            if ((!mrun && mcnt == N) || (mrun && mcnt == hop)) begin
               exp_q.push_back(pack_hist());
               mrun     = 1'b1;
               mcnt     = 0;
               emit_exp = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(input int s);
      rst      = 1'b1;
      s_valid  = 1'b0;
      flush    = 1'b0;
      emit_exp = 1'b0;
      @(posedge clk);
      #1;
      sel   = s;
      hop   = (s == 0) ? 8 : ((s == 1) ? 4 : 1);
      x_exp = '0;
      exp_q.delete();
      hist.delete();
      mcnt = 0;
      mrun = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset(0);
      mon_on = 1'b1;
      checks++;
      if (rdy[0] !== 1'b1 || fcnt[0] !== 8'd0 || fv[0] !== 1'b0 || fov[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got=rdy%b cnt%0d fv%b fov%b exp=rdy1 cnt0 fv0 fov0",
                  rdy[0], fcnt[0], fv[0], fov[0]);
      end
      checks++;
      if (win_of(0) !== '0) begin
         failures++;
         $display("FAIL reset_window got=%h exp=0", win_of(0));
      end
   endtask

   task automatic test_basic_fill();
      int f0, o0;
      do_reset(0);
      f0 = frames_seen;
      o0 = fov_seen;
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b0);
      idle(LAT + 2);
      checks++;
      if (frames_seen - f0 !== 1 || fov_seen - o0 !== 1) begin
         failures++;
         $display("FAIL basic_counts got=frames%0d fov%0d exp=frames1 fov1", frames_seen - f0, fov_seen - o0);
      end
      checks++;
      if (xo[0][0] !== 12'd1 || xo[0][7] !== 12'd8 || fcnt[0] !== 8'd1) begin
         failures++;
         $display("FAIL basic_values got=x0=%0d x7=%0d cnt=%0d exp=x0=1 x7=8 cnt=1", xo[0][0], xo[0][7], fcnt[0]);
      end
   endtask

   task automatic test_overlap();
      int f0;
      do_reset(1);
      f0 = frames_seen;
      for (int i = 1; i <= 16; i++) drive(1'b1, W'(i), 1'b0);
      idle(LAT + 2);
      checks++;
      if (frames_seen - f0 !== 3) begin
         failures++;
         $display("FAIL overlap_frames got=%0d exp=3", frames_seen - f0);
      end
      checks++;
      if (xo[1][0] !== 12'd9 || xo[1][7] !== 12'd16) begin
         failures++;
         $display("FAIL overlap_last got=x0=%0d x7=%0d exp=x0=9 x7=16", xo[1][0], xo[1][7]);
      end
   endtask

   task automatic test_gapped();
      int f0;
      do_reset(0);
      f0 = frames_seen;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, W'($urandom_range(0, 4095)), 1'b0);
         idle(2);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, W'($urandom_range(0, 4095)), 1'b0);
         idle($urandom_range(0, 3));
      end
      idle(LAT + 2);
      checks++;
      if (frames_seen - f0 !== 2) begin
         failures++;
         $display("FAIL gapped_frames got=%0d exp=2", frames_seen - f0);
      end
   endtask

   task automatic test_flush();
      int f0, o0;
      do_reset(0);
      f0 = frames_seen;
      o0 = fov_seen;
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b0);
      // Flush while that frame is still in the latency pipe.
      drive(1'b1, 12'hABC, 1'b1);
      for (int i = 20; i < 25; i++) drive(1'b1, W'(i), 1'b0);
      drive(1'b1, 12'hABC, 1'b1);
      for (int i = 40; i < 47; i++) drive(1'b1, W'(i), 1'b0);
      checks++;
      if (frames_seen - f0 !== 1) begin
         failures++;
         $display("FAIL flush_early got=%0d exp=1", frames_seen - f0);
      end
      drive(1'b1, W'(47), 1'b0);
      idle(LAT + 2);
      checks++;
      if (frames_seen - f0 !== 2 || fov_seen - o0 !== 2) begin
         failures++;
         $display("FAIL flush_counts got=frames%0d fov%0d exp=frames2 fov2", frames_seen - f0, fov_seen - o0);
      end
      checks++;
      if (xo[0][0] !== 12'd40 || xo[0][7] !== 12'd47) begin
         failures++;
         $display("FAIL flush_window got=x0=%0d x7=%0d exp=x0=40 x7=47", xo[0][0], xo[0][7]);
      end
   endtask

   task automatic test_reset_mid();
      int o0;
      do_reset(0);
      for (int i = 1; i <= 8; i++) drive(1'b1, W'(i + 100), 1'b0);
      o0 = fov_seen;
      idle(1);
      do_reset(0);
      idle(LAT + 1);
      checks++;
      if (fov_seen - o0 !== 0) begin
         failures++;
         $display("FAIL reset_mid_fov got=%0d exp=0", fov_seen - o0);
      end
      checks++;
      if (win_of(0) !== '0 || fcnt[0] !== 8'd0 || rdy[0] !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_state got=win%h cnt%0d rdy%b exp=win0 cnt0 rdy1", win_of(0), fcnt[0], rdy[0]);
      end
   endtask

   task automatic test_back_to_back();
      int f0, o0;
      do_reset(2);
      f0 = frames_seen;
      o0 = fov_seen;
      for (int i = 0; i < N + 255; i++) drive(1'b1, W'($urandom_range(0, 4095)), 1'b0);
      checks++;
      if (fcnt[2] !== 8'd0) begin
         failures++;
         $display("FAIL wrap_cnt got=%0d exp=0", fcnt[2]);
      end
      idle(LAT + 2);
      checks++;
      if (frames_seen - f0 !== 256 || fov_seen - o0 !== 256) begin
         failures++;
         $display("FAIL hop1_counts got=frames%0d fov%0d exp=256", frames_seen - f0, fov_seen - o0);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_overlap();
      test_gapped();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL leftover_frames got=%0d exp=0", exp_q.size());
      end
      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fft_frame_buffer_5.md
# fft_frame_buffer_5

Upstream feeder for the 8-point pipelined FFT (`fft_top_5`). Accepts a serial stream of 12-bit audio samples under a valid/ready handshake and assembles them into a sliding window with a configurable hop. It presents the window as eight parallel, stable inputs `x_0`..`x_7`. It also tracks the FFT pipeline latency, so downstream logic receives a strobe aligned to valid FFT outputs.

## Interface
- `DATA_W`, 12, sample width; equals FFT input width.
- `N`, 8, window length; fixed to FFT size.
- `HOP`, 8, new samples per frame, legal range 1..N. 8 gives no overlap; 4 gives 50 % overlap.
- `FFT_LAT`, 3, FFT register stages from `x_*` change to valid `y_*`.

- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous; discards the partial window and returns to FILL.
- `s_valid`  in  1  sample valid.
- `s_data`  in  DATA_W  sample, unsigned ADC code, passed through unchanged.
- `s_ready`  out  1  sample ready.
- `x_0` … `x_7`  out  DATA_W each  window to FFT; `x_0` is the oldest sample, `x_7` the newest.
- `frame_valid`  out  1  one-cycle pulse: a new window is on `x_*`.
- `fft_out_valid`  out  1  one-cycle pulse: the FFT outputs for that window are valid.
- `frame_cnt`  out  8  count of emitted frames; wraps modulo 256.

## Operation
- Accept a sample when `s_valid && s_ready`. `s_ready` is 0 while `rst` is high and 1 otherwise; the block never back-pressures.
- Shift register `win[0..N-1]`: on accept, `win[i] <= win[i+1]` and `win[N-1] <= s_data`.
- Output hold register `x_*` is separate from `win`. It is loaded from `win` only at frame emission, so it stays constant while the FFT pipeline runs.
- State machine:
  - FILL: counts accepts in `fill_cnt`, 0..N. When the accepted sample makes `fill_cnt` equal N, the block emits a frame, clears `hop_cnt`, and goes to RUN.
  - RUN: counts accepts in `hop_cnt`. When the accepted sample makes `hop_cnt` equal HOP, the block emits a frame and clears `hop_cnt`. There is no return to FILL except on `flush` or `rst`.
- Frame emission:
  - `x_*` load the window *including* the sample accepted on that edge.
  - `frame_valid` pulses.
  - `frame_cnt` increments.
- Latency pipe: a FFT_LAT-bit shift register fed by `frame_valid`; `fft_out_valid` is its last bit. Pulses from back-to-back frames (HOP=1) propagate independently.
- Boundary conditions:
  - `flush` together with `s_valid`: flush wins and the sample is dropped. `fill_cnt` and `hop_cnt` clear and the state goes to FILL. `x_*`, `frame_cnt` and the latency pipe are untouched, so in-flight FFT results still signal.
  - `rst` mid-frame: clears everything, including the latency pipe. No stale `fft_out_valid` appears.
  - `frame_cnt` at 255 goes to 0 on the next emission.
  - HOP=1 in RUN: every accepted sample emits a frame.

## Timing
- Reset values: `x_*`=0, `win`=0, `frame_valid`=0, `fft_out_valid`=0, `frame_cnt`=0, `s_ready`=0 while `rst` is high, state FILL with both counters 0.
- If the sample completing a frame is accepted at edge k:
  - `x_*` are new from edge k.
  - `frame_valid` is high during cycle k → k+1.
  - `fft_out_valid` is high exactly FFT_LAT cycles later, from edge k+FFT_LAT.
- Minimum frame spacing is HOP accepted samples. With continuous `s_valid` that is HOP cycles, and the first frame arrives N cycles after the first accept.
- All outputs are registered. There is no combinational path from `s_valid` or `s_data` to any output.

## Structure
- Shared package `fft_pkg_5`: `DATA_W`, `FFT_N`=8, `FFT_LAT_DEFAULT`, and the sample type `sample_t` (DATA_W bits).
- One sub-module, `valid_delay_line`: parameterised depth, 1-bit shift register with synchronous reset. It is reusable for aligning other pipeline strobes.
- Remaining logic stays flat: window shifter, FILL/RUN FSM, hold register, frame counter.

## Test plan
- Basic fill: reset, then stream 1..8 continuously, HOP=8. Required: `frame_valid` one cycle after the 8th accept; `x_0`=1 … `x_7`=8; `fft_out_valid` FFT_LAT cycles after `frame_valid`; `frame_cnt`=1.
- Overlap: HOP=4, stream 1..16. Required: frames hold {1..8}, {5..12} and {9..16}, emitted after samples 8, 12 and 16; between emissions `x_*` is stable.
- Gapped input: `s_valid` toggling 1,0,0,1… with HOP=8. Required: identical windows to the continuous case, and emission only on the accepting edge of the 8th valid sample.
- Flush: flush after 5 samples, with `s_valid` high in the same cycle carrying 0xABC. Required: 0xABC is dropped; the next frame needs 8 fresh samples; a frame already in the latency pipe still produces `fft_out_valid`.
- Reset mid-operation: assert `rst` one cycle after `frame_valid`. Required: no `fft_out_valid`; all outputs 0; `s_ready`=0 during reset and 1 on the cycle after release.
- Counter wrap and HOP=1: HOP=1, emit 256 frames continuously. Required: `frame_valid` high every cycle in RUN; `frame_cnt` goes from 255 to 0; `fft_out_valid` high continuously, delayed by FFT_LAT.
